sample_unpacker: RTL and testbench

//  Inverse of the capture-side byte packer: reads packed OUTPUT-byte memory words
//  and re-expands them into INPUT-byte samples, one byte per channel.

---
 rtl/logip_pkg.sv | 25 ++
 rtl/channel_scatter.sv | 33 +++
 rtl/sample_unpacker.sv | 119 +++++++++++
 tb/tb_sample_unpacker.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/logip_pkg.sv
// logip_pkg: shared byte/sample typedefs and helpers for the sample readback path.
// Revision 1.0
`default_nettype none

package logip_pkg;

  localparam int INPUT_BYTES  = 4;
  localparam int OUTPUT_BYTES = 4;

  typedef logic [7:0]                 byte_t;
  typedef byte_t [INPUT_BYTES-1:0]    sample_t;
  typedef byte_t [OUTPUT_BYTES-1:0]   word_t;

  function automatic int unsigned popcount(input logic [31:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 32; i++) begin
      n = n + 32'(v[i]);
    end
    return n;
  endfunction

endpackage

`default_nettype wire

// File: rtl/channel_scatter.sv
// channel_scatter: distributes the oldest-first packed bytes onto the enabled channel slots.
// Revision 1.0
`default_nettype none

module channel_scatter
  import logip_pkg::*;
#(
  parameter int INPUT = INPUT_BYTES
) (
  input  logic [INPUT-1:0]      cfg_i,
  input  logic [INPUT-1:0][7:0] bytes_i,
  output logic [INPUT-1:0][7:0] sample_o
);

  localparam int IW = (INPUT > 1) ? $clog2(INPUT) : 1;

  logic [IW-1:0] idx;

  // bytes_i[INPUT-1] is the oldest byte; it lands on the highest enabled channel.
  always_comb begin
    sample_o = '0;
    idx      = IW'(INPUT - 1);
    for (int ch = INPUT - 1; ch >= 0; ch--) begin
      if (!cfg_i[ch]) begin
        sample_o[ch] = bytes_i[idx];
        idx          = idx - IW'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/sample_unpacker.sv
// sample_unpacker: re-expands packed memory words into per-channel byte samples.
// Revision 1.0
`default_nettype none

module sample_unpacker
  import logip_pkg::*;
#(
  parameter int INPUT  = INPUT_BYTES,
  parameter int OUTPUT = OUTPUT_BYTES
) (
  input  logic                   clk_i,
  input  logic                   rst_in,
  input  logic                   cfg_stb_i,
  input  logic [INPUT-1:0]       cfg_i,
  input  logic                   en_i,
  input  logic                   stb_i,
  output logic                   rdy_o,
  input  logic [OUTPUT-1:0][7:0] d_i,
  output logic                   stb_o,
  input  logic                   ack_i,
  output logic [INPUT-1:0][7:0]  q_o,
  output logic                   empty_o
);

  localparam int BW   = INPUT + OUTPUT - 1;
  localparam int CNTW = $clog2(INPUT + OUTPUT);
  localparam int TW   = $clog2(BW + INPUT);

  logic [INPUT-1:0]        cfg_q, cfg_d;
  logic [CNTW-1:0]         cnt_q, cnt_d;
  byte_t [BW-1:0]          buf_q, buf_d;
  byte_t [INPUT-1:0]       q_q, q_d;
  logic                    stb_q, stb_d;

  logic [CNTW-1:0]         w_n;
  logic                    w_n_zero;
  logic                    w_accept;
  logic                    w_load;
  byte_t [BW+INPUT-1:0]    w_ext;
  logic [TW-1:0]           w_top;
  byte_t [INPUT-1:0]       w_win;
  logic [INPUT-1:0][7:0]   w_sample;

  assign w_n      = CNTW'(INPUT - int'(popcount(32'(cfg_q))));
  assign w_n_zero = (w_n == '0);
  assign rdy_o    = (cnt_q < w_n) | w_n_zero;
  assign w_accept = en_i & stb_i & rdy_o;
  assign w_load   = en_i & ~w_n_zero & (cnt_q >= w_n) & (~stb_q | ack_i);

  // Zero padding below the buffer keeps the window index non-negative for any cnt.
  assign w_ext = {buf_q, {INPUT{8'h00}}};
  assign w_top = TW'(cnt_q) + TW'(INPUT - 1);

  always_comb begin
    w_win = '0;
    for (int j = 0; j < INPUT; j++) begin
      w_win[INPUT-1-j] = w_ext[w_top - TW'(j)];
    end
  end

  channel_scatter #(
    .INPUT    (INPUT)
  ) u_scatter (
    .cfg_i    (cfg_q),
    .bytes_i  (w_win),
    .sample_o (w_sample)
  );

  always_comb begin
    cfg_d = cfg_q;
    cnt_d = cnt_q;
    buf_d = buf_q;
    q_d   = q_q;
    stb_d = stb_q;
    if (cfg_stb_i) begin
      cfg_d = cfg_i;
      cnt_d = '0;
      buf_d = '0;
      q_d   = '0;
      stb_d = 1'b0;
    end else begin
      // With every channel disabled, accepted words are simply dropped.
      if (w_accept && !w_n_zero) begin
        buf_d = (BW*8)'({buf_q, d_i});
        cnt_d = cnt_q + CNTW'(OUTPUT);
      end
      if (w_load) begin
        q_d   = w_sample;
        stb_d = 1'b1;
        cnt_d = cnt_q - w_n;
      end else if (en_i && ack_i) begin
        stb_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      cfg_q <= '0;
      cnt_q <= '0;
      buf_q <= '0;
      q_q   <= '0;
      stb_q <= 1'b0;
    end else begin
      cfg_q <= cfg_d;
      cnt_q <= cnt_d;
      buf_q <= buf_d;
      q_q   <= q_d;
      stb_q <= stb_d;
    end
  end

  assign stb_o   = stb_q;
  assign q_o     = q_q;
  assign empty_o = (cnt_q == '0) & ~stb_q;

endmodule

`default_nettype wire

// File: tb/tb_sample_unpacker.sv
// tb_sample_unpacker: directed vector bench for sample_unpacker (INPUT=4, OUTPUT=4).
// Revision 1.0
`default_nettype none

module tb_sample_unpacker;

  logic            clk_i;
  logic            rst_in;
  logic            cfg_stb_i;
  logic [3:0]      cfg_i;
  logic            en_i;
  logic            stb_i;
  logic            rdy_o;
  logic [3:0][7:0] d_i;
  logic            stb_o;
  logic            ack_i;
  logic [3:0][7:0] q_o;
  logic            empty_o;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic [3:0]       cfg;
    logic [1:0]       nw;
    logic [2:0]       ns;
    logic [2:0][31:0] w;
    logic [3:0][31:0] s;
  } vec_t;

  vec_t vecs [5];

  sample_unpacker #(
    .INPUT     (4),
    .OUTPUT    (4)
  ) dut (
    .clk_i     (clk_i),
    .rst_in    (rst_in),
    .cfg_stb_i (cfg_stb_i),
    .cfg_i     (cfg_i),
    .en_i      (en_i),
    .stb_i     (stb_i),
    .rdy_o     (rdy_o),
    .d_i       (d_i),
    .stb_o     (stb_o),
    .ack_i     (ack_i),
    .q_o       (q_o),
    .empty_o   (empty_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at 100000, expected completion");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic wait_stb(input string nm);
    int k;
    k = 0;
    while (stb_o !== 1'b1 && k < 20) begin
      @(negedge clk_i);
      k++;
    end
    if (stb_o !== 1'b1) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: stb_o=%b after 20 cycles, expected 1", nm, stb_o);
    end
  endtask

  task automatic flush(input logic [3:0] c);
    @(negedge clk_i);
    cfg_stb_i = 1'b1;
    cfg_i     = c;
    stb_i     = 1'b0;
    @(negedge clk_i);
    cfg_stb_i = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int  widx;
    int  sidx;
    int  cyc;
    logic acc;
    flush(v.cfg);
    ack_i = 1'b1;
    widx  = 0;
    sidx  = 0;
    cyc   = 0;
    stb_i = (v.nw != 0);
    d_i   = v.w[0];
    while ((widx < int'(v.nw) || sidx < int'(v.ns)) && cyc < 40) begin
      acc = stb_i && rdy_o && en_i;
      @(negedge clk_i);
      cyc++;
      if (acc) widx++;
      if (stb_o) begin
        if (sidx < int'(v.ns))
          chk($sformatf("vec%0d.sample%0d", idx, sidx), q_o, v.s[2'(sidx)]);
        else
          chk($sformatf("vec%0d.extra_stb", idx), 32'(stb_o), 32'd0);
        sidx++;
      end
      stb_i = (widx < int'(v.nw));
      d_i   = (widx < int'(v.nw)) ? v.w[2'(widx)] : 32'h0;
    end
    if (cyc >= 40) begin
      n_vec++;
      n_err++;
      $display("FAIL vec%0d.timeout: got %0d samples, expected %0d", idx, sidx, v.ns);
    end
    stb_i = 1'b0;
    @(negedge clk_i);
    chk($sformatf("vec%0d.empty_after", idx), 32'(empty_o), 32'd1);
  endtask

  initial begin
    vecs[0] = '{cfg: 4'b0000, nw: 2'd1, ns: 3'd1,
                w: {32'h0, 32'h0, 32'hA3A2A1A0},
                s: {32'h0, 32'h0, 32'h0, 32'hA3A2A1A0}};
    vecs[1] = '{cfg: 4'b1010, nw: 2'd1, ns: 3'd2,
                w: {32'h0, 32'h0, 32'h11223344},
                s: {32'h0, 32'h0, 32'h00330044, 32'h00110022}};
    vecs[2] = '{cfg: 4'b0001, nw: 2'd3, ns: 3'd4,
                w: {32'h090A0B0C, 32'h05060708, 32'h01020304},
                s: {32'h0A0B0C00, 32'h07080900, 32'h04050600, 32'h01020300}};
    vecs[3] = '{cfg: 4'b0111, nw: 2'd1, ns: 3'd4,
                w: {32'h0, 32'h0, 32'hDEADBEEF},
                s: {32'hEF000000, 32'hBE000000, 32'hAD000000, 32'hDE000000}};
    vecs[4] = '{cfg: 4'b1000, nw: 2'd3, ns: 3'd4,
                w: {32'h090A0B0C, 32'h05060708, 32'h01020304},
                s: {32'h000A0B0C, 32'h00070809, 32'h00040506, 32'h00010203}};

    rst_in    = 1'b0;
    cfg_stb_i = 1'b0;
    cfg_i     = 4'b0000;
    en_i      = 1'b1;
    stb_i     = 1'b0;
    d_i       = '0;
    ack_i     = 1'b1;

    #3;
    chk("reset.q", q_o, 32'h0);
    chk("reset.stb", 32'(stb_o), 32'd0);
    chk("reset.rdy", 32'(rdy_o), 32'd1);
    chk("reset.empty", 32'(empty_o), 32'd1);
    @(negedge clk_i);
    rst_in = 1'b1;

    for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

    // Latency: accept at edge k, sample visible after edge k+1.
    flush(4'b0000);
    ack_i = 1'b1;
    stb_i = 1'b1;
    d_i   = 32'hC0FFEE11;
    @(negedge clk_i);
    stb_i = 1'b0;
    chk("lat.stb_k", 32'(stb_o), 32'd0);
    chk("lat.empty_k", 32'(empty_o), 32'd0);
    @(negedge clk_i);
    chk("lat.stb_k1", 32'(stb_o), 32'd1);
    chk("lat.q_k1", q_o, 32'hC0FFEE11);
    chk("lat.rdy_k1", 32'(rdy_o), 32'd1);
    @(negedge clk_i);
    chk("lat.empty_end", 32'(empty_o), 32'd1);

    // Backpressure: output frozen while ack_i is low.
    flush(4'b1010);
    ack_i = 1'b0;
    stb_i = 1'b1;
    d_i   = 32'h11223344;
    @(negedge clk_i);
    stb_i = 1'b0;
    wait_stb("bp.wait");
    for (int k = 0; k < 5; k++) begin
      chk("bp.hold_q", q_o, 32'h00110022);
      chk("bp.hold_stb", 32'(stb_o), 32'd1);
      chk("bp.hold_rdy", 32'(rdy_o), 32'd0);
      if (k < 4) @(negedge clk_i);
    end
    ack_i = 1'b1;
    @(negedge clk_i);
    chk("bp.second_q", q_o, 32'h00330044);
    chk("bp.second_stb", 32'(stb_o), 32'd1);
    @(negedge clk_i);
    chk("bp.done_stb", 32'(stb_o), 32'd0);
    chk("bp.done_empty", 32'(empty_o), 32'd1);

    // Flush mid-stream with three leftover bytes; a same-cycle word is dropped.
    flush(4'b0111);
    ack_i = 1'b0;
    stb_i = 1'b1;
    d_i   = 32'hDEADBEEF;
    @(negedge clk_i);
    stb_i = 1'b0;
    wait_stb("fl.wait");
    chk("fl.first_q", q_o, 32'hDE000000);
    cfg_stb_i = 1'b1;
    cfg_i     = 4'b0000;
    stb_i     = 1'b1;
    d_i       = 32'hEEEEEEEE;
    @(negedge clk_i);
    cfg_stb_i = 1'b0;
    stb_i     = 1'b0;
    chk("fl.stb", 32'(stb_o), 32'd0);
    chk("fl.q", q_o, 32'h0);
    chk("fl.rdy", 32'(rdy_o), 32'd1);
    chk("fl.empty", 32'(empty_o), 32'd1);
    ack_i = 1'b1;
    stb_i = 1'b1;
    d_i   = 32'h55667788;
    @(negedge clk_i);
    stb_i = 1'b0;
    @(negedge clk_i);
    chk("fl.new_stb", 32'(stb_o), 32'd1);
    chk("fl.new_q", q_o, 32'h55667788);

    // Asynchronous reset mid-stream.
    flush(4'b0111);
    ack_i = 1'b0;
    stb_i = 1'b1;
    d_i   = 32'hDEADBEEF;
    @(negedge clk_i);
    stb_i = 1'b0;
    wait_stb("rst.wait");
    #1 rst_in = 1'b0;
    #1;
    chk("rst.stb", 32'(stb_o), 32'd0);
    chk("rst.q", q_o, 32'h0);
    chk("rst.rdy", 32'(rdy_o), 32'd1);
    chk("rst.empty", 32'(empty_o), 32'd1);
    @(negedge clk_i);
    rst_in = 1'b1;
    ack_i  = 1'b1;
    stb_i  = 1'b1;
    d_i    = 32'h12345678;
    @(negedge clk_i);
    stb_i = 1'b0;
    @(negedge clk_i);
    chk("rst.new_stb", 32'(stb_o), 32'd1);
    chk("rst.new_q", q_o, 32'h12345678);

    // All channels disabled: words accepted and discarded.
    flush(4'b1111);
    ack_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      stb_i = 1'b1;
      d_i   = 32'hA5A5A500 | 32'(k);
      chk("n0.rdy", 32'(rdy_o), 32'd1);
      @(negedge clk_i);
    end
    stb_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("n0.stb", 32'(stb_o), 32'd0);
      chk("n0.empty", 32'(empty_o), 32'd1);
      @(negedge clk_i);
    end

    // en_i low: offered word is not taken.
    flush(4'b0000);
    en_i  = 1'b0;
    stb_i = 1'b1;
    d_i   = 32'hCAFEF00D;
    @(negedge clk_i);
    @(negedge clk_i);
    chk("en.empty", 32'(empty_o), 32'd1);
    chk("en.stb", 32'(stb_o), 32'd0);
    stb_i = 1'b0;
    en_i  = 1'b1;
    @(negedge clk_i);
    chk("en.empty_after", 32'(empty_o), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
